// File: rtl/bus_arbiter.sv
// Two-master external bus sequencer: BR/BA ownership, address + data phase with wait states, per-requester OK/ERR.
// Core vs DMA arbitration with DMA starvation limit and DMA burst lock; bus parks across back-to-back transfers.
module bus_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int BA_TIMEOUT  = 64,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d0_rq,
  input  logic        d1_rq,
  input  logic        d0_rw,
  input  logic        d1_rw,
  input  logic        d0_if,
  input  logic [15:0] d0_addr,
  input  logic [15:0] d1_addr,
  input  logic [7:0]  d0_wdata,
  input  logic [7:0]  d1_wdata,
  input  logic        d1_lock,
  output logic        d0_ok,
  output logic        d1_ok,
  output logic        d0_err,
  output logic        d1_err,
  output logic [7:0]  rdata,
  output logic [1:0]  gnt,
  output logic        br,
  input  logic        ba,
  output logic        bus_oe,
  output logic        bus_doe,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic        bus_fi,
  output logic        bus_dt,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE} state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [3:0]  wait_cnt;
  logic [3:0]  starve_cnt;
  logic        own_dma;
  logic [7:0]  op_wd;

  logic        in_done, e0, e1, any_rq, win_dma, tmo_hit, park_lock, do_grant;
  logic [15:0] sel_a;
  logic        sel_rw;
  logic [7:0]  sel_wd;

  // The requester finishing in DONE still shows its old RQ, so it is masked there.
  assign in_done   = (state == S_DONE);
  assign e0        = d0_rq & ~(in_done & ~own_dma);
  assign e1        = d1_rq & ~(in_done & own_dma);
  assign any_rq    = e0 | e1;
  assign win_dma   = (e1 & d1_lock & own_dma) | (e1 & (starve_cnt == 4'(STARVE_MAX))) | ~e0;
  assign tmo_hit   = (BA_TIMEOUT != 0) && (tmo_cnt == 16'(BA_TIMEOUT - 1));
  assign park_lock = d1_lock & own_dma;
  assign do_grant  = ba & any_rq & ((state == S_REQ) | (in_done & ~park_lock));

  assign sel_a  = win_dma ? d1_addr  : d0_addr;
  assign sel_rw = win_dma ? d1_rw    : d0_rw;
  assign sel_wd = win_dma ? d1_wdata : d0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      own_dma    <= 1'b0;
      op_wd      <= '0;
      d0_ok      <= 1'b0;
      d1_ok      <= 1'b0;
      d0_err     <= 1'b0;
      d1_err     <= 1'b0;
      rdata      <= '0;
      gnt        <= 2'b00;
      br         <= 1'b0;
      bus_oe     <= 1'b0;
      bus_doe    <= 1'b0;
      bus_a      <= '0;
      bus_rw     <= 1'b1;
      bus_fi     <= 1'b0;
      bus_dt     <= 1'b0;
      bus_do     <= '0;
    end else begin
      d0_ok  <= 1'b0;
      d1_ok  <= 1'b0;
      d0_err <= 1'b0;
      d1_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_rq) begin
            state   <= S_REQ;
            br      <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        S_REQ: begin
          if (!any_rq) begin
            state <= S_IDLE;
            br    <= 1'b0;
          end else if (!ba) begin
            if (tmo_hit) begin
              state   <= S_DONE;
              br      <= 1'b0;
              own_dma <= win_dma;
              gnt     <= {win_dma, ~win_dma};
              d0_ok   <= ~win_dma;
              d0_err  <= ~win_dma;
              d1_ok   <= win_dma;
              d1_err  <= win_dma;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        S_ADDR: begin
          state    <= S_DATA;
          wait_cnt <= '0;
          if (!bus_rw) begin
            bus_doe <= 1'b1;
            bus_do  <= op_wd;
          end
        end
        S_DATA: begin
          if (wait_cnt == 4'(WAIT_STATES)) begin
            state   <= S_DONE;
            bus_oe  <= 1'b0;
            bus_doe <= 1'b0;
            if (bus_rw) rdata <= bus_di;
            d0_ok   <= ~own_dma;
            d1_ok   <= own_dma;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DONE: begin
          gnt <= 2'b00;
          // A locked DMA burst goes back through REQ so its fresh RQ can be seen.
          if (any_rq || park_lock) begin
            state   <= S_REQ;
            br      <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            state <= S_IDLE;
            br    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (do_grant) begin
        state   <= S_ADDR;
        br      <= 1'b1;
        own_dma <= win_dma;
        gnt     <= {win_dma, ~win_dma};
        op_wd   <= sel_wd;
        bus_oe  <= 1'b1;
        bus_a   <= sel_a;
        bus_rw  <= sel_rw;
        bus_fi  <= win_dma ? 1'b0 : d0_if;
        bus_dt  <= win_dma;
        if (win_dma)
          starve_cnt <= '0;
        else if (e1 && starve_cnt != 4'(STARVE_MAX))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequencer and arbiter for the BrainForge8 external bus. Shares the bus between two internal masters: Driver0 (core, instruction/data) and Driver1 (DMA). Negotiates ownership with the outside world through BR/BA. Runs each transfer as an address phase followed by a data phase with wait states, and reports completion or failure per requester. It sits between CORE/DMA and the bus pin drivers; D1_ERR feeds the IRC DMA-fail trigger.

## Interface
- WAIT_STATES, 0: extra data-phase cycles per transfer (0–15).
- BA_TIMEOUT, 64: max cycles spent waiting for BA before failing; 0 disables the timeout.
- STARVE_MAX, 4: consecutive core grants allowed while DMA is pending (1–15).

- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- D0_RQ / D1_RQ  in  1  transfer request, level; hold with operands until OK.
- D0_RW / D1_RW  in  1  1 = read, 0 = write.
- D0_IF  in  1  core transfer is an instruction fetch.
- D0_ADDR / D1_ADDR  in  16  transfer address.
- D0_WDATA / D1_WDATA  in  8  write data.
- D1_LOCK  in  1  DMA burst lock; keeps the grant on DMA between transfers.
- D0_OK / D1_OK  out  1  one-cycle completion pulse.
- D0_ERR / D1_ERR  out  1  qualifies OK: the transfer failed because BA timed out.
- RDATA  out  8  read data; valid with OK, held until the next read completes.
- GNT  out  2  one-hot owner: [0] core, [1] DMA.
- BR  out  1  external bus request.
- BA  in  1  external bus available.
- BUS_OE  out  1  drive enable for A/RW/FI/DT.
- BUS_DOE  out  1  drive enable for D; high only during the data phase of a write.
- BUS_A  out  16, BUS_RW  out  1, BUS_FI  out  1, BUS_DT  out  1, BUS_DO  out  8  bus values.
- BUS_DI  in  8  sampled data bus.

## Operation
- States:
  - IDLE
  - REQ: BR=1, waiting for BA.
  - ADDR: address phase, 1 cycle.
  - DATA: 1+WAIT_STATES cycles.
  - DONE: 1 cycle; OK pulses.
- IDLE to REQ when any RQ=1.
- REQ:
  - BA=1 goes to ADDR, latching the winner and its operands.
  - All RQ=0 goes to IDLE and drops BR. This is the only legal abort point.
  - The timeout counter reaching BA_TIMEOUT goes to DONE with ERR=1 for the current winner; no bus cycle runs.
- Arbitration is evaluated when entering ADDR:
  - D1_LOCK=1 with DMA as last owner wins for DMA.
  - Otherwise, a starvation count equal to STARVE_MAX wins for DMA.
  - Otherwise, the core wins if D0_RQ=1, else DMA.
- Starvation counter:
  - Increments on each core grant while D1_RQ=1.
  - Clears on a DMA grant.
  - Saturates at STARVE_MAX.
- ADDR/DATA outputs:
  - BUS_OE=1, and BUS_A, BUS_RW come from the latched operands.
  - BUS_FI=D0_IF for the core, 0 for DMA.
  - BUS_DT=1 for DMA, 0 for the core.
- Writes: BUS_DO=WDATA and BUS_DOE=1 throughout DATA.
- Reads: RDATA captures BUS_DI on the last DATA cycle.
- DONE:
  - Pulses OK (and ERR if failed) for the latched owner.
  - BUS_OE=0 and BUS_DOE=0.
  - Exit: any RQ pending (excluding the requester that just completed, because its RQ is sampled one cycle late) and BA=1 goes directly to ADDR (bus parking, BR stays 1). RQ pending and BA=0 goes to REQ. No RQ goes to IDLE with BR=0.
  - The requester that just completed is ignored in the DONE cycle.
- BA is sampled only in REQ and DONE. Deassertion during ADDR/DATA is ignored; the transfer always completes.
- GNT is one-hot for the owner from ADDR through DONE, and 00 otherwise.

## Timing
- Reset values:
  - BR=0, BUS_OE=0, BUS_DOE=0.
  - BUS_A=0x0000, BUS_RW=1, BUS_FI=0, BUS_DT=0, BUS_DO=0x00.
  - RDATA=0x00, OK/ERR=0, GNT=00.
  - Counters clear and state is IDLE.
- Reset mid-transfer: all outputs return to reset values immediately (async). No OK is issued.
- Latency with RQ sampled at edge n and BA=1:
  - REQ at n+1, ADDR at n+2, DATA at n+3..n+3+W, DONE at n+4+W.
  - OK is visible during cycle n+4+W.
- Back-to-back parked transfer: DONE to the next ADDR takes 1 cycle. Bus idle gap is 1 cycle (BUS_OE=0 in DONE).
- Timeout: ERR/OK are in the cycle after BA_TIMEOUT cycles of BA=0 in REQ.
- Simultaneous D0_RQ and D1_RQ with a starvation count below STARVE_MAX: the core wins.

## Test plan
- Core read, W=0, BA=1, D0_ADDR=0x1234, BUS_DI=0xA5 -> BUS_A=0x1234 during ADDR/DATA, BUS_RW=1, BUS_FI=D0_IF. D0_OK in cycle n+4 with RDATA=0xA5.
- DMA write, W=2, D1_WDATA=0x3C -> BUS_DT=1, BUS_DOE=1 for exactly 3 cycles carrying 0x3C. D1_OK in cycle n+6.
- Both request continuously, STARVE_MAX=4, no lock -> grant order core×4, DMA, core×4, DMA. GNT is one-hot throughout.
- BA held 0, BA_TIMEOUT=64 -> BR high for 64 cycles, then OK=1 and ERR=1 for the owner, BR=0, BUS_OE never asserted.
- D1_LOCK=1 for a 3-transfer DMA burst while D0_RQ=1 -> the core is blocked until the DONE after D1_LOCK falls. BR stays high between transfers.
- Async RST low during DATA of a write -> BUS_DOE, BUS_OE and BR drop in the same cycle. No OK. After release the machine is in IDLE.
